// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared ALU op codes, controller states and helpers
// for the ALU time-sharing controller.
package alu_share_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SGT = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward
// from last_grant+1 (mod N).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  int            cand;
  logic [IW-1:0] ci;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    ci    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant) + k) % N;
      ci   = IW'(cand);
      if (!found && req[ci]) begin
        found     = 1'b1;
        idx       = ci;
        grant[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one external ALU between
// NUM_REQ requesters. Optional counters: ALU_SHARE_PERF_EN.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand1,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand2,
  input  logic [NUM_REQ*OP_W-1:0]   req_alu_op,
  output logic [DATA_W-1:0]         alu_operand1,
  output logic [DATA_W-1:0]         alu_operand2,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      busy
`ifdef ALU_SHARE_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]     perf_grant_cnt,
  output logic [15:0]               perf_stall_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state_q, state_d;
  logic [IW-1:0]       owner_q, last_grant_q;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       win_idx;
  logic [DATA_W-1:0]   res_q;
  logic                zero_q;
  logic                accept;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .idx        (win_idx)
  );

  assign accept = (state_q == IDLE) && (|req_valid);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_op       <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      owner_q      <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_operand1 <= req_operand1[int'(win_idx)*DATA_W +: DATA_W];
        alu_operand2 <= req_operand2[int'(win_idx)*DATA_W +: DATA_W];
        alu_op       <= req_alu_op[int'(win_idx)*OP_W +: OP_W];
        owner_q      <= win_idx;
        last_grant_q <= win_idx;
      end
      if (state_q == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_SHARE_PERF_EN
  logic [15:0] gcnt [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    always_ff @(posedge clk) begin
      if (rst) gcnt[i] <= '0;
      else if (req_valid[i] && req_ready[i]) gcnt[i] <= sat_inc(gcnt[i]);
    end
    assign perf_grant_cnt[i*16 +: 16] = gcnt[i];
  end

  always_ff @(posedge clk) begin
    if (rst) perf_stall_cnt <= '0;
    else if ((|req_valid) && busy) perf_stall_cnt <= sat_inc(perf_stall_cnt);
  end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed self-checking bench with a
// behavioural ALU model driven by the DUT's registered ALU inputs.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_operand1;
  logic [63:0] req_operand2;
  logic [5:0]  req_alu_op;
  logic [31:0] alu_operand1, alu_operand2;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        busy;
`ifdef ALU_SHARE_PERF_EN
  logic [31:0] perf_grant_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NUM_REQ(2), .DATA_W(32), .OP_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_operand1 (req_operand1),
    .req_operand2 (req_operand2),
    .req_alu_op   (req_alu_op),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .busy         (busy)
`ifdef ALU_SHARE_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_operand1 + alu_operand2;
      3'b001: alu_result = alu_operand1 - alu_operand2;
      3'b010: alu_result = alu_operand1 & alu_operand2;
      3'b011: alu_result = alu_operand1 | alu_operand2;
      3'b100: alu_result = alu_operand1 ^ alu_operand2;
      3'b101: alu_result = {31'd0, $signed(alu_operand1) < $signed(alu_operand2)};
      3'b110: alu_result = {31'd0, $signed(alu_operand1) > $signed(alu_operand2)};
      default: alu_result = {31'd0, alu_operand1 == alu_operand2};
    endcase
    alu_zero = (alu_op >= 3'b101) ? alu_result[0] : (alu_result == 0);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    req_operand1[i*32 +: 32] = a;
    req_operand2[i*32 +: 32] = b;
    req_alu_op[i*3 +: 3]     = op;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got rdy=%b vld=%b busy=%b exp 00 00 0",
               req_ready, rsp_valid, busy);
    end
    checks++;
    if (alu_operand1 !== 0 || alu_operand2 !== 0 || alu_op !== 3'b000) begin
      errors++;
      $display("FAIL reset_alu got %h %h %b exp 0 0 000",
               alu_operand1, alu_operand2, alu_op);
    end
    checks++;
    if (rsp_result !== 0 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got %h %b exp 0 0", rsp_result, rsp_zero);
    end
  endtask

  task automatic test_single();
    step();
    set_req(0, 32'd5, 32'd3, 3'b000);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready got %b exp 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (alu_operand1 !== 32'd5 || busy !== 1'b1 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL single_exec got op1=%0d busy=%b rdy=%b exp 5 1 00",
               alu_operand1, busy, req_ready);
    end
    step();
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd8 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got vld=%b res=%0d z=%b exp 01 8 0",
               rsp_valid, rsp_result, rsp_zero);
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL single_done got busy=%b vld=%b exp 0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [3];
    logic [31:0] exp_r [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_r[0] = 32'd6; exp_r[1] = 32'h30; exp_r[2] = 32'd6;
    do_reset();
    set_req(0, 32'd10, 32'd4, 3'b001);
    set_req(1, 32'hF0, 32'h3C, 3'b010);
    req_valid = 2'b11;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (req_ready !== exp_g[n]) begin
        errors++;
        $display("FAIL rr_grant%0d got %b exp %b", n, req_ready, exp_g[n]);
      end
      step();
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL rr_exec%0d got rdy=%b exp 00", n, req_ready);
      end
      step();
      #1;
      checks++;
      if (rsp_valid !== exp_g[n] || rsp_result !== exp_r[n]) begin
        errors++;
        $display("FAIL rr_rsp%0d got vld=%b res=%h exp %b %h",
                 n, rsp_valid, rsp_result, exp_g[n], exp_r[n]);
      end
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_back_pressure();
    step();
    set_req(1, 32'd7, 32'd7, 3'b111);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_grant got %b exp 10", req_ready);
    end
    step();
    req_valid = 2'b01;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 32'd1 || rsp_zero !== 1'b1 ||
          req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b res=%0d z=%b rdy=%b exp 10 1 1 00",
                 c, rsp_valid, rsp_result, rsp_zero, req_ready);
      end
      step();
    end
    rsp_ready = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL bp_hs_rdy got %b exp 00", req_ready);
    end
    step();
    rsp_ready = 2'b00;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_after got %b exp 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd6) begin
      errors++;
      $display("FAIL bp_r0_rsp got vld=%b res=%0d exp 01 6", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_wrong_bit();
    set_req(1, 32'hFF, 32'h0F, 3'b100);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    rsp_ready = 2'b01;
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      checks++;
      if (rsp_valid !== 2'b10 || busy !== 1'b1 || rsp_result !== 32'hF0) begin
        errors++;
        $display("FAIL wrong_bit%0d got vld=%b busy=%b res=%h exp 10 1 f0",
                 c, rsp_valid, busy, rsp_result);
      end
    end
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wrong_bit_done got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'd9, 32'd1, 3'b000);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 ||
        alu_operand1 !== 0 || alu_op !== 3'b000 || rsp_result !== 0) begin
      errors++;
      $display("FAIL mid_rst got busy=%b vld=%b rdy=%b op1=%h op=%b res=%h exp reset",
               busy, rsp_valid, req_ready, alu_operand1, alu_op, rsp_result);
    end
    step();
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL mid_rst_norsp got %b exp 00", rsp_valid);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_rst_prio got %b exp 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
  endtask

`ifdef ALU_SHARE_PERF_EN
  task automatic test_perf();
    do_reset();
    set_req(0, 32'd1, 32'd1, 3'b000);
    set_req(1, 32'd2, 32'd2, 3'b000);
    req_valid = 2'b11;
    for (int n = 0; n < 5; n++) begin
      if (n == 4) req_valid = 2'b01;
      step();
      step();
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    #1;
    checks++;
    if (perf_grant_cnt !== {16'd2, 16'd3}) begin
      errors++;
      $display("FAIL perf_grant got %h exp 00020003", perf_grant_cnt);
    end
    checks++;
    if (perf_stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL perf_stall got %0d exp 10", perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    rsp_ready    = '0;
    req_operand1 = '0;
    req_operand2 = '0;
    req_alu_op   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_wrong_bit();
    test_reset_mid();
`ifdef ALU_SHARE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that time-shares the single 32-bit `alu` between NUM_REQ requesters, e.g. the execute stage and the branch-compare unit.
- Requesters present operands and a 3-bit op with a valid/ready handshake.
- The block grants one requester at a time using round-robin priority, drives the ALU input registers, captures result and zero, and returns them on a per-requester valid/ready response channel.
- It sits between the requesters and the ALU instance; the ALU itself stays combinational and external.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 32, operand/result width; must match ALU.
- OP_W, 3, ALU op width. Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SGT, 111 EQ.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_operand1  in  NUM_REQ*DATA_W  flattened; slice i belongs to requester i.
- req_operand2  in  NUM_REQ*DATA_W  flattened.
- req_alu_op  in  NUM_REQ*OP_W  flattened.
- alu_operand1  out  DATA_W  registered, to ALU operand1.
- alu_operand2  out  DATA_W  registered, to ALU operand2.
- alu_op  out  OP_W  registered, to ALU alu_op.
- alu_result  in  DATA_W  from ALU result.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  DATA_W  shared response data bus.
- rsp_zero  out  1  shared response zero flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req_valid, compute winner w by round-robin starting at (last_grant+1) mod NUM_REQ.
    - req_ready[w]=1 combinationally in the same cycle.
    - On that edge: alu_operand1/2/op <= slice w, owner <= w, last_grant <= w, go EXEC.
    - No valid -> stay IDLE, req_ready=0.
  - EXEC: ALU inputs are stable.
    - On the edge: res_q <= alu_result, zero_q <= alu_zero, go RESP.
    - req_ready=0.
  - RESP: rsp_valid[owner]=1; rsp_result=res_q, rsp_zero=zero_q.
    - rsp_ready[owner]=1 -> go IDLE.
    - Otherwise hold all response outputs stable indefinitely.
    - rsp_ready on non-owner bits is ignored.
- Latency: accept in cycle T -> rsp_valid at T+2. Minimum issue interval is 3 cycles, since a new grant is possible in the cycle after the response handshake.
- Requesters must hold operands/op stable while req_valid && !req_ready. A requester may deassert valid before it is granted.
- req_ready is never asserted outside IDLE. At most one bit of req_ready/rsp_valid is high.
- Round-robin:
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority.
  - Under continuous requests from all requesters, grant order is 0,1,…,NUM_REQ-1,0…
- ALU input registers hold their last value outside EXEC; no gating.
- Result and zero are forwarded unmodified. The controller does not reinterpret zero.
- Reset values: state=IDLE, alu_operand1/2=0, alu_op=000, res_q=0, zero_q=0, owner=0, req_ready=0, rsp_valid=0, busy=0.
- Reset mid-operation: an in-flight request is dropped with no response. The requester must reissue.

Optional Feature:
Macro ALU_SHARE_PERF_EN.
- Defined: adds output perf_grant_cnt (NUM_REQ*16, flattened) and perf_stall_cnt (16).
  - perf_grant_cnt[i] increments on each req_valid[i]&&req_ready[i]; saturates at 16'hFFFF.
  - perf_stall_cnt increments each cycle any req_valid is high while state != IDLE; saturates.
  - Both counters clear on rst.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package alu_share_pkg: ALU op localparams (ALU_ADD..ALU_EQ), state enum typedef {IDLE,EXEC,RESP}.
- One sub-module rr_arbiter: inputs req vector and last_grant; outputs one-hot grant and encoded index. It is purely combinational.

Test Plan:
- Reset then requester 0 only, op1=5, op2=3, op=000: req_ready[0] in cycle T, alu_operand1=5 at T+1, rsp_valid[0] with rsp_result=8 at T+2, rsp_ready=1 -> busy=0 at T+3.
- Both requesters valid continuously (r0 SUB 10-4, r1 AND F0&3C): grants in order r0, r1, r0; responses 6 then 0x30, each one-hot on the correct rsp_valid bit.
- Back-pressure: r1 op 111 with 7,7; hold rsp_ready=0 for 5 cycles.
  - rsp_valid[1], rsp_result=1 and rsp_zero=1 held stable throughout.
  - r0 request pending meanwhile gets no req_ready until 1 cycle after the handshake.
- rsp_ready asserted on the wrong bit (rsp_ready[0] while owner=1): no state change; response is still held.
- rst asserted in EXEC: next cycle state=IDLE, all outputs at reset values, no rsp_valid. After reset, requester 0 has priority over 1.
- With ALU_SHARE_PERF_EN: 3 grants to r0 and 2 to r1 -> perf_grant_cnt = {2,3}; stall count matches cycles with a pending valid while busy.
